// File: rtl/sweep_pkg.sv
//------------------------------------------------------------------------------
// sweep_pkg : shared types and limits for the truth-table sweeper.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int MAX_NIN = 6;

endpackage

`default_nettype wire

// File: rtl/sweep_settle_timer.sv
//------------------------------------------------------------------------------
// sweep_settle_timer : counts SETTLE extra cycles per vector, flags expiry.
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sweep_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LIMIT = CW'(SETTLE);

    logic [CW-1:0] r_cnt;

    // Wraps to zero on expiry so the next vector starts a fresh settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= expire ? '0 : r_cnt + 1'b1;
        end
    end

    assign expire = (r_cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
//------------------------------------------------------------------------------
// truth_table_sweeper : drives all 2**N_IN vectors into a combinational unit,
//                       captures its truth table and grades it against a golden.
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_count
);

    localparam int            TBL     = 1 << N_IN;
    localparam logic [N_IN:0] LAST    = (N_IN + 1)'(TBL - 1);
    localparam logic [N_IN:0] ACC_MAX = (N_IN + 1)'(TBL);

    generate
        if (N_IN < 1 || N_IN > MAX_NIN) begin : g_nin_range_check
            $error("truth_table_sweeper: N_IN out of range");
        end
    endgenerate

    sweep_state_t  state;
    sweep_state_t  next_state;
    logic [N_IN:0] r_idx;
    logic [N_IN:0] r_acc;
    logic [N_IN:0] w_idx_next;
    logic [N_IN-1:0] w_vec;
    logic          w_expire;
    logic          w_sample;
    logic          w_timer_clear;
    logic          w_launch;

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_timer_clear),
        .enable (state == DRIVE),
        .expire (w_expire)
    );

    assign w_idx_next = r_idx + 1'b1;
    assign w_vec      = r_idx[N_IN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !abort) next_state = DRIVE;
            DRIVE:   if (abort) next_state = IDLE;
                     else if (w_sample && r_idx == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == DRIVE) || (state == DONE);
        w_launch      = (state == IDLE) && start && !abort;
        w_sample      = (state == DRIVE) && w_expire && !abort;
        w_timer_clear = (state != DRIVE) || abort;
    end

    // dut_in is advanced on the sampling edge so that a fresh vector is already
    // settled when SETTLE=0 samples on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_acc          <= '0;
            dut_in         <= '0;
            table_out      <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
        end else begin
            done <= 1'b0;
            if (w_launch) begin
                r_idx     <= '0;
                r_acc     <= '0;
                dut_in    <= '0;
                table_out <= '0;
            end else if (busy && abort) begin
                dut_in <= '0;
            end else if (w_sample) begin
                table_out[w_vec] <= dut_out;
                if (dut_out != expected[w_vec] && r_acc != ACC_MAX) begin
                    r_acc <= r_acc + 1'b1;
                end
                if (r_idx != LAST) begin
                    r_idx  <= w_idx_next;
                    dut_in <= w_idx_next[N_IN-1:0];
                end
            end else if (state == DONE) begin
                done           <= 1'b1;
                pass           <= (table_out == expected);
                mismatch_count <= r_acc;
            end
        end
    end

endmodule

`default_nettype wire
